// File: rtl/uart_sdram_pkg.sv
// Shared types and constants for the UART-to-SDRAM command path.
// Reused by the sequencer, the arbiter bench and the TX echo block.
package uart_sdram_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_WR_REQ  = 3'd2;
    localparam logic [2:0] S_WR_SEND = 3'd3;
    localparam logic [2:0] S_RD_REQ  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_PAYLOAD = S_PAYLOAD,
        ST_WR_REQ  = S_WR_REQ,
        ST_WR_SEND = S_WR_SEND,
        ST_RD_REQ  = S_RD_REQ
    } state_t;

    localparam logic [1:0] ERR_BADCMD  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    localparam logic [7:0] CMD_WR_DEF = 8'h55;
    localparam logic [7:0] CMD_RD_DEF = 8'hAA;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload byte buffer: indexed store from the parser,
// indexed read for the write streamer.
module uart_cmd_buf #(
    parameter int DATA_BYTES = 4,
    parameter int IW         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [7:0]    wr_byte,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_byte
);

    logic [DATA_BYTES*8-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (clr) begin
            mem <= '0;
        end else if (wr_en && (wr_idx < IW'(DATA_BYTES))) begin
            mem[wr_idx*8 +: 8] <= wr_byte;
        end
    end

    // Index DATA_BYTES is reachable on the final stream cycle.
    assign rd_byte = (rd_idx < IW'(DATA_BYTES)) ?
                     mem[rd_idx*8 +: 8] : 8'h00;

endmodule

// File: rtl/uart_cmd_sched.sv
// UART command sequencer: parses write/read frames and drives
// the SDRAM arbiter request/ack handshake and write stream.
module uart_cmd_sched
    import uart_sdram_pkg::*;
#(
    parameter int         DATA_BYTES  = 4,
    parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
    parameter int         TIMEOUT_CYC = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic       wr_req,
    input  logic       wr_ack,
    output logic [7:0] wr_data,
    output logic       wr_data_vld,
    output logic       rd_req,
    input  logic       rd_ack,
    output logic       busy,
    output logic       err_flag,
    output logic [1:0] err_code
);

    localparam int CW = $clog2(DATA_BYTES + 1);
    localparam int GW = $clog2(TIMEOUT_CYC);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gap;
    logic          store;
    logic          err_now;
    logic [1:0]    err_nxt;
    logic [7:0]    rd_byte;
    logic          last;
    logic          sent_all;
    logic          gap_hit;

    assign last     = (cnt == CW'(DATA_BYTES - 1));
    assign sent_all = (cnt == CW'(DATA_BYTES));
    // gap equals cycles since the last byte; err lands one cycle later
    assign gap_hit  = (gap == GW'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        store     = 1'b0;
        err_now   = 1'b0;
        err_nxt   = ERR_BADCMD;
        unique case (state)
            ST_IDLE: begin
                if (po_flag) begin
                    if (rx_data == CMD_WR) begin
                        state_nxt = ST_PAYLOAD;
                    end else if (rx_data == CMD_RD) begin
                        state_nxt = ST_RD_REQ;
                    end else begin
                        err_now = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (po_flag) begin
                    store = 1'b1;
                    if (last) state_nxt = ST_WR_REQ;
                end else if (gap_hit) begin
                    state_nxt = ST_IDLE;
                    err_now   = 1'b1;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            ST_WR_REQ: begin
                if (wr_ack) state_nxt = ST_WR_SEND;
            end
            ST_WR_SEND: begin
                if (sent_all) state_nxt = ST_IDLE;
            end
            ST_RD_REQ: begin
                if (rd_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (po_flag && (state == ST_WR_REQ ||
                        state == ST_WR_SEND ||
                        state == ST_RD_REQ)) begin
            err_now = 1'b1;
            err_nxt = ERR_OVERRUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            gap         <= '0;
            wr_data     <= 8'h00;
            wr_data_vld <= 1'b0;
            err_flag    <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            err_flag <= err_now;
            if (err_now) err_code <= err_nxt;
            case (state)
                ST_IDLE: begin
                    cnt         <= '0;
                    gap         <= GW'(1);
                    wr_data_vld <= 1'b0;
                end
                ST_PAYLOAD: begin
                    if (store) begin
                        cnt <= last ? '0 : cnt + CW'(1);
                        gap <= GW'(1);
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                ST_WR_REQ: begin
                    if (wr_ack) begin
                        wr_data     <= rd_byte;
                        wr_data_vld <= 1'b1;
                        cnt         <= CW'(1);
                    end
                end
                ST_WR_SEND: begin
                    if (sent_all) begin
                        wr_data_vld <= 1'b0;
                    end else begin
                        wr_data <= rd_byte;
                        cnt     <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    uart_cmd_buf #(
        .DATA_BYTES (DATA_BYTES),
        .IW         (CW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == ST_IDLE),
        .wr_en   (store),
        .wr_idx  (cnt),
        .wr_byte (rx_data),
        .rd_idx  (cnt),
        .rd_byte (rd_byte)
    );

    assign wr_req = (state == ST_WR_REQ);
    assign rd_req = (state == ST_RD_REQ);
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Scoreboard bench for uart_cmd_sched: expected write bytes and
// error codes are queued at stimulus time and popped on output.
module tb_uart_cmd_sched;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       wr_req;
    logic       wr_ack;
    logic [7:0] wr_data;
    logic       wr_data_vld;
    logic       rd_req;
    logic       rd_ack;
    logic       busy;
    logic       err_flag;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;
    int vld_cyc = 0;
    int wreq_cyc = 0;
    int rreq_cyc = 0;
    logic [7:0] exp_wr[$];
    logic [1:0] exp_err[$];

    uart_cmd_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .po_flag     (po_flag),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .wr_data     (wr_data),
        .wr_data_vld (wr_data_vld),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .busy        (busy),
        .err_flag    (err_flag),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_data_vld) begin
                vld_cyc++;
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_data", wr_data, exp_wr.pop_front());
            end
            if (err_flag) begin
                if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
                else chk("err_code", err_code, exp_err.pop_front());
            end
            if (wr_req) wreq_cyc++;
            if (rd_req) rreq_cyc++;
            if (wr_req && rd_req) chk("req_exclusive", 1, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        po_flag = 1'b1;
        tick();
        po_flag = 1'b0;
    endtask

    // Runs a write frame up to the first wr_req cycle.
    task automatic frame_to_req(input logic [7:0] b0,
                                input logic [7:0] b1,
                                input logic [7:0] b2,
                                input logic [7:0] b3);
        exp_wr.push_back(b0);
        exp_wr.push_back(b1);
        exp_wr.push_back(b2);
        exp_wr.push_back(b3);
        send_byte(8'h55);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        chk("wr_req_early", wr_req, 0);
        send_byte(b3);
        chk("wr_req_rise", wr_req, 1);
    endtask

    task automatic ack_wr(input int dly);
        repeat (dly) tick();
        chk("wr_req_held", wr_req, 1);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("wr_req_fall", wr_req, 0);
    endtask

    task automatic finish_wr(input int v0);
        repeat (6) tick();
        chk("busy_after_wr", busy, 0);
        chk("vld_cycles", vld_cyc - v0, 4);
        chk("wr_q_empty", exp_wr.size(), 0);
    endtask

    task automatic outputs_zero(input string tag);
        chk(tag, {wr_req, rd_req, busy, err_flag, wr_data_vld,
                  wr_data, err_code}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int w0;
        int r0;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        po_flag = 1'b0;
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        #3;
        outputs_zero("reset_outputs");
        #19;
        rst_n = 1'b1;
        tick();

        // Write frame with ack 3 cycles after request
        v0 = vld_cyc;
        frame_to_req(8'h11, 8'h22, 8'h33, 8'h44);
        ack_wr(3);
        finish_wr(v0);

        // Read with ack on first request cycle
        v0 = vld_cyc;
        w0 = wreq_cyc;
        r0 = rreq_cyc;
        send_byte(8'hAA);
        chk("rd_req_rise", rd_req, 1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("rd_req_fall", rd_req, 0);
        chk("rd_busy_low", busy, 0);
        tick();
        chk("rd_req_cycles", rreq_cyc - r0, 1);
        chk("rd_no_wr_req", wreq_cyc - w0, 0);
        chk("rd_no_wr_vld", vld_cyc - v0, 0);

        // Bad command then a good frame
        exp_err.push_back(2'b01);
        send_byte(8'h3C);
        chk("bad_flag", err_flag, 1);
        chk("bad_idle", busy, 0);
        tick();
        chk("bad_pulse_end", err_flag, 0);
        v0 = vld_cyc;
        frame_to_req(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        ack_wr(1);
        finish_wr(v0);

        // Timeout after 55,11,22
        w0 = wreq_cyc;
        exp_err.push_back(2'b10);
        send_byte(8'h55);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (597) tick();
        chk("tmo_not_yet", err_flag, 0);
        tick();
        chk("tmo_flag", err_flag, 1);
        chk("tmo_code", err_code, 2);
        chk("tmo_idle", busy, 0);
        tick();
        chk("tmo_no_wr_req", wreq_cyc - w0, 0);

        // Byte on the timeout boundary keeps the frame alive
        v0 = vld_cyc;
        exp_wr.push_back(8'h11);
        exp_wr.push_back(8'h22);
        exp_wr.push_back(8'h33);
        exp_wr.push_back(8'h44);
        send_byte(8'h55);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (597) tick();
        send_byte(8'h33);
        chk("bnd_no_err", err_flag, 0);
        chk("bnd_busy", busy, 1);
        send_byte(8'h44);
        chk("bnd_wr_req", wr_req, 1);
        ack_wr(2);
        finish_wr(v0);

        // Overrun while wr_req pending
        v0 = vld_cyc;
        frame_to_req(8'h11, 8'h22, 8'h33, 8'h44);
        exp_err.push_back(2'b11);
        send_byte(8'h77);
        chk("ovr_flag", err_flag, 1);
        chk("ovr_code", err_code, 3);
        ack_wr(2);
        finish_wr(v0);

        // Reset in the middle of the write stream
        frame_to_req(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        ack_wr(0);
        tick();
        rst_n = 1'b0;
        exp_wr.delete();
        #1;
        outputs_zero("rst_mid_outputs");
        tick();
        rst_n = 1'b1;
        tick();
        outputs_zero("rst_after_release");
        v0 = vld_cyc;
        frame_to_req(8'h0F, 8'h1E, 8'h2D, 8'h3C);
        ack_wr(1);
        finish_wr(v0);

        chk("err_q_empty", exp_err.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
